// File: rtl/key_event_conditioner.sv
// Turns the four raw active-low push-buttons into clean one-cycle menu navigation
// events (synchronize, debounce, press-edge, up/down auto-repeat, priority arbitration).
module key_event_conditioner #(
  parameter int DEBOUNCE_CYC  = 20000,
  parameter int REPEAT_DELAY  = 6000000,
  parameter int REPEAT_PERIOD = 1500000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [3:0] i_key_n,
  output logic       o_select,
  output logic       o_back,
  output logic       o_up,
  output logic       o_down,
  output logic [3:0] o_held
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] R_FIRE  = RW'(REPEAT_DELAY);
  // Reloading one above DELAY-PERIOD makes the gap between fires exactly REPEAT_PERIOD.
  localparam logic [RW-1:0] R_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  localparam int K_DOWN   = 0;
  localparam int K_UP     = 1;
  localparam int K_BACK   = 2;
  localparam int K_SELECT = 3;

  logic [3:0]    sync1, sync2;
  logic [3:0]    key_s;
  logic [3:0]    held, held_d;
  logic [DW-1:0] db_cnt [4];
  logic [RW-1:0] rcnt   [2];
  logic [1:0]    rep;
  logic          rpt_allow;
  logic [3:0]    press, cand, grant;
  logic [3:0]    evt;

  // NOTE: every sequential block uses non-blocking (<=) so all registers update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= i_key_n;
      sync2 <= sync1;
    end
  end

  assign key_s = ~sync2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      held   <= '0;
      held_d <= '0;
      for (int k = 0; k < 4; k++) db_cnt[k] <= '0;
    end else begin
      held_d <= held;
      for (int k = 0; k < 4; k++) begin
        if (key_s[k] == held[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          held[k]   <= key_s[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + DW'(1);
        end
      end
    end
  end

  // Holding up and down together parks both repeat counters so neither auto-repeats.
  assign rpt_allow = REPEAT_EN && i_en && !(held[K_UP] && held[K_DOWN]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < 2; k++) rcnt[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!held[k] || !rpt_allow)  rcnt[k] <= '0;
        else if (rcnt[k] == R_FIRE)  rcnt[k] <= R_RELOAD;
        else                         rcnt[k] <= rcnt[k] + RW'(1);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) rep[k] = held[k] && rpt_allow && (rcnt[k] == R_FIRE);
  end

  assign press = held & ~held_d;
  assign cand  = press | {2'b00, rep};

  // NOTE: grant gets a default before the priority chain, so no latch is inferred.
  always_comb begin
    grant = '0;
    if      (cand[K_BACK])   grant[K_BACK]   = 1'b1;
    else if (cand[K_SELECT]) grant[K_SELECT] = 1'b1;
    else if (cand[K_UP])     grant[K_UP]     = 1'b1;
    else if (cand[K_DOWN])   grant[K_DOWN]   = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) evt <= '0;
    else       evt <= i_en ? grant : '0;
  end

  assign o_select = evt[K_SELECT];
  assign o_back   = evt[K_BACK];
  assign o_up     = evt[K_UP];
  assign o_down   = evt[K_DOWN];
  assign o_held   = held;

endmodule

// File: tb/tb_key_event_conditioner.sv
// Bench for key_event_conditioner: vector table plus hand-written corner sequences;
// expected events are queued with their cycle number and matched as the DUT emits them.
module tb_key_event_conditioner;

  localparam int D  = 8;
  localparam int RD = 40;
  localparam int RP = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic       o_select, o_back, o_up, o_down;
  logic [3:0] o_held;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int         cyc;
    logic [3:0] ev;
  } exp_t;
  exp_t q[$];

  typedef struct {
    string      name;
    logic [3:0] mask;
    int         hold;
    logic [3:0] exp_ev;
    int         exp_n;
  } vec_t;
  vec_t vecs[6];

  key_event_conditioner #(
    .DEBOUNCE_CYC(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_key_n(key_n),
    .o_select(o_select), .o_back(o_back), .o_up(o_up), .o_down(o_down),
    .o_held(o_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [3:0] e);
    exp_t x;
    x.cyc = c;
    x.ev  = e;
    q.push_back(x);
  endtask

  // Event order on the bus matches key order: {select, back, up, down}.
  always @(negedge clk) begin
    logic [3:0] ev;
    exp_t x;
    ev = {o_select, o_back, o_up, o_down};
    if (ev != 4'b0000) begin
      check("one_event_per_cycle", $countones(ev), 1);
      if (q.size() == 0) begin
        check("unexpected_event", int'(ev), 0);
      end else begin
        x = q.pop_front();
        check("event_cycle", cyc, x.cyc);
        check("event_code", int'(ev), int'(x.ev));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int n, f, r, e;

    vecs[0] = '{"back_single",   4'b0100, 30,  4'b0100, 1};
    vecs[1] = '{"select_hold",   4'b1000, 200, 4'b1000, 1};
    vecs[2] = '{"up_repeat",     4'b0010, 200, 4'b0010, 11};
    vecs[3] = '{"back_select",   4'b1100, 30,  4'b0100, 1};
    vecs[4] = '{"up_down_both",  4'b0011, 200, 4'b0010, 1};
    vecs[5] = '{"down_single",   4'b0001, 30,  4'b0001, 1};

    tick(2);
    check("rst_held", int'(o_held), 0);
    check("rst_events", int'({o_select, o_back, o_up, o_down}), 0);
    rst = 1'b0;
    tick(5);
    check("idle_held", int'(o_held), 0);

    // Clean press of back: o_held from N+D+2, event at N+D+3.
    tick(1);
    n = cyc;
    key_n[2] = 1'b0;
    push(n + D + 3, 4'b0100);
    tick(D + 1);
    check("clean_held_early", int'(o_held[2]), 0);
    tick(1);
    check("clean_held_on", int'(o_held[2]), 1);
    tick(20);
    key_n = 4'hF;
    tick(25);
    check("clean_queue_empty", q.size(), 0);

    foreach (vecs[i]) begin
      tick(1);
      n = cyc;
      key_n = ~vecs[i].mask;
      push(n + D + 3, vecs[i].exp_ev);
      for (int k = 1; k < vecs[i].exp_n; k++)
        push(n + D + 3 + RD + RP * (k - 1), vecs[i].exp_ev);
      tick(vecs[i].hold);
      check({vecs[i].name, "_held"}, int'(o_held), int'(vecs[i].mask));
      key_n = 4'hF;
      tick(D + 6);
      check({vecs[i].name, "_released"}, int'(o_held), 0);
      tick(10);
      check({vecs[i].name, "_queue_empty"}, q.size(), 0);
    end

    // Bouncing press on down: 3-cycle phases are ignored, final edge F gives one event.
    tick(1);
    for (int i = 0; i < 10; i++) begin
      key_n[0] = i[0];
      tick(3);
    end
    f = cyc;
    key_n[0] = 1'b0;
    push(f + D + 3, 4'b0001);
    tick(12);
    for (int i = 0; i < 9; i++) begin
      key_n[0] = ~i[0];
      tick(3);
    end
    tick(30);
    check("bounce_released", int'(o_held), 0);
    check("bounce_queue_empty", q.size(), 0);

    // Reset mid-debounce with the key let go: nothing emitted, held cleared.
    tick(1);
    key_n[2] = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(1);
    check("rst_mid_held", int'(o_held), 0);
    rst = 1'b0;
    key_n = 4'hF;
    tick(30);
    check("rst_mid_after", int'(o_held), 0);
    check("rst_mid_queue_empty", q.size(), 0);

    // Key kept down through reset: accepted D+2 cycles after release, one event.
    tick(1);
    key_n[3] = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    r = cyc;
    push(r + D + 3, 4'b1000);
    tick(D + 1);
    check("rst_hold_early", int'(o_held[3]), 0);
    tick(1);
    check("rst_hold_on", int'(o_held[3]), 1);
    tick(10);
    key_n = 4'hF;
    tick(25);
    check("rst_hold_queue_empty", q.size(), 0);

    // Press and release while disabled: debounce still tracks, no event.
    tick(1);
    en = 1'b0;
    key_n[3] = 1'b0;
    tick(30);
    check("en_low_held", int'(o_held), 4'b1000);
    key_n = 4'hF;
    tick(20);
    en = 1'b1;
    tick(10);
    check("en_low_queue_empty", q.size(), 0);

    // Enable rises with down held: only the restarted repeat fires.
    en = 1'b0;
    key_n[0] = 1'b0;
    tick(20);
    e = cyc;
    en = 1'b1;
    push(e + RD + 1, 4'b0001);
    tick(44);
    key_n = 4'hF;
    tick(25);
    check("en_rise_released", int'(o_held), 0);
    check("en_rise_queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
